// File: rtl/rvfi_trk_pkg.sv
// Shared types for the RVFI retire tracker: capture, late and retire records,
// the per-lane stage entry, and a lane popcount helper.
package rvfi_trk_pkg;

    localparam int unsigned XLEN      = 32;
    localparam int unsigned MAX_LANES = 16;

    typedef struct packed {
        logic [XLEN-1:0] inst;
        logic [XLEN-1:0] pc_rdata;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [XLEN-1:0] rs1_rdata;
        logic [XLEN-1:0] rs2_rdata;
        logic [4:0]      rd_addr;
        logic            load_regfile;
        logic            trap;
    } rec_t;

    typedef struct packed {
        logic [XLEN-1:0] pc_wdata;
        logic [XLEN-1:0] mem_addr;
        logic [3:0]      mem_rmask;
        logic [3:0]      mem_wmask;
        logic [XLEN-1:0] mem_wdata;
        logic [XLEN-1:0] mem_rdata;
    } late_t;

    typedef struct packed {
        rec_t            rec;
        late_t           late;
        logic [XLEN-1:0] rd_wdata;
    } retire_t;

    typedef struct packed {
        logic    valid;
        retire_t data;
    } stage_entry_t;

    // Number of set bits among the lowest n lanes of v.
    function automatic int unsigned popcount(input logic [MAX_LANES-1:0] v,
                                             input int unsigned n);
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < MAX_LANES; i++) begin
            if ((i < n) && v[i]) begin
                cnt = cnt + 1;
            end
        end
        return cnt;
    endfunction

endpackage

// File: rtl/rvfi_retire_tracker_if.sv
// Bundle between the core probe points and the retire tracker: per-stage
// stall/flush, capture and late records, writeback data, and the retire view.
interface rvfi_retire_tracker_if #(
    parameter int unsigned DEPTH   = 3,
    parameter int unsigned LANES   = 2,
    parameter int unsigned ORDER_W = 64
);
    import rvfi_trk_pkg::*;

    logic [DEPTH-1:0]             stall;
    logic [DEPTH-1:0]             flush;
    logic [LANES-1:0]             in_valid;
    rec_t  [LANES-1:0]            in_rec;
    late_t [LANES-1:0]            late_rec;
    logic [LANES-1:0][XLEN-1:0]   wb_rd_wdata;
    logic [LANES-1:0]             commit;
    retire_t [LANES-1:0]          out_rec;
    logic [LANES-1:0][ORDER_W-1:0] order;
    logic                         halt;

    modport master (
        output stall, flush, in_valid, in_rec, late_rec, wb_rd_wdata,
        input  commit, out_rec, order, halt
    );

    modport slave (
        input  stall, flush, in_valid, in_rec, late_rec, wb_rd_wdata,
        output commit, out_rec, order, halt
    );

endinterface

// File: rtl/rvfi_trk_stage.sv
// One LANES-wide shadow stage: holds on stall, clears on flush, takes a bubble
// when the upstream stage is stalled, and optionally merges the late fields.
module rvfi_trk_stage
    import rvfi_trk_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter bit          MERGE = 1'b0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     stall,
    input  logic                     stall_up,
    input  logic                     flush,
    input  stage_entry_t [LANES-1:0] ent_i,
    input  late_t        [LANES-1:0] late_i,
    output stage_entry_t [LANES-1:0] ent_o
);

    logic    [LANES-1:0] vld_d, vld_q;
    retire_t [LANES-1:0] data_d, data_q;
    logic                unused_late;

    assign unused_late = MERGE ? 1'b0 : ^late_i;

    always_comb begin
        vld_d  = vld_q;
        data_d = data_q;
        for (int unsigned k = 0; k < LANES; k++) begin
            if (!stall) begin
                // A stalled upstream keeps its record, so taking it here too would duplicate it.
                vld_d[k]  = ent_i[k].valid & ~stall_up;
                data_d[k] = ent_i[k].data;
                if (MERGE) begin
                    data_d[k].late = late_i[k];
                end
            end
            if (flush) begin
                vld_d[k] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    always_ff @(posedge clk) begin
        data_q <= data_d;
    end

    always_comb begin
        ent_o = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            ent_o[k].valid = vld_q[k];
            ent_o[k].data  = data_q[k];
        end
    end

endmodule

// File: rtl/rvfi_retire_tracker.sv
// Multi-lane RVFI shadow pipeline: DEPTH stage registers carry records from
// capture to retire, then retire, order numbering and halt detection.
module rvfi_retire_tracker
    import rvfi_trk_pkg::*;
#(
    parameter int unsigned DEPTH     = 3,
    parameter int unsigned LANES     = 2,
    parameter int unsigned MEM_STAGE = 1,
    parameter int unsigned ORDER_W   = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    rvfi_retire_tracker_if.slave  bus
);

    localparam int unsigned LAST = DEPTH - 1;

    stage_entry_t [LANES-1:0]      cap_ent;
    stage_entry_t [LANES-1:0]      stg [DEPTH];

    logic [LANES-1:0]              commit;
    retire_t [LANES-1:0]           out_rec;
    logic [LANES-1:0][ORDER_W-1:0] order;
    logic [MAX_LANES-1:0]          commit_ext;
    logic [ORDER_W-1:0]            base_d, base_q;
    logic                          halt_d, halt_q;

    // Capture: only the early record exists here; late and writeback fields fill in downstream.
    always_comb begin
        cap_ent = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            cap_ent[k].valid    = bus.in_valid[k];
            cap_ent[k].data.rec = bus.in_rec[k];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        if (i == 0) begin : g_first
            rvfi_trk_stage #(
                .LANES (LANES),
                .MERGE (1'b0)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .stall    (bus.stall[0]),
                .stall_up (1'b0),
                .flush    (bus.flush[0]),
                .ent_i    (cap_ent),
                .late_i   (bus.late_rec),
                .ent_o    (stg[0])
            );
        end else begin : g_next
            rvfi_trk_stage #(
                .LANES (LANES),
                .MERGE (i == int'(MEM_STAGE) + 1)
            ) u_stage (
                .clk      (clk),
                .rst_n    (rst_n),
                .stall    (bus.stall[i]),
                .stall_up (bus.stall[i-1]),
                .flush    (bus.flush[i]),
                .ent_i    (stg[i-1]),
                .late_i   (bus.late_rec),
                .ent_o    (stg[i])
            );
        end
    end

    // Retire: last stage presented combinationally, rd_wdata merged here.
    always_comb begin
        commit  = '0;
        out_rec = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            commit[k]           = stg[LAST][k].valid & ~bus.stall[LAST];
            out_rec[k]          = stg[LAST][k].data;
            out_rec[k].rd_wdata = (stg[LAST][k].data.rec.rd_addr == 5'd0) ?
                                  '0 : bus.wb_rd_wdata[k];
        end
    end

    // Lanes below a bubble still number contiguously; only committing lanes consume orders.
    always_comb begin
        commit_ext = MAX_LANES'(commit);
        base_d     = base_q + ORDER_W'(popcount(commit_ext, LANES));
        halt_d     = halt_q;
        order      = '0;
        for (int unsigned k = 0; k < LANES; k++) begin
            order[k] = base_q + ORDER_W'(popcount(commit_ext, k));
            if (commit[k] &&
                (out_rec[k].late.pc_wdata == out_rec[k].rec.pc_rdata) &&
                (out_rec[k].rec.pc_rdata != '0)) begin
                halt_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            base_q <= '0;
            halt_q <= 1'b0;
        end else begin
            base_q <= base_d;
            halt_q <= halt_d;
        end
    end

    assign bus.commit  = commit;
    assign bus.out_rec = out_rec;
    assign bus.order   = order;
    assign bus.halt    = halt_q;

endmodule

// File: tb/tb_rvfi_retire_tracker.sv
// Directed bench for rvfi_retire_tracker (DEPTH=3, LANES=2, MEM_STAGE=1):
// per-cycle expected commit patterns plus an in-order queue of expected retiring pcs.
module tb_rvfi_retire_tracker;
    import rvfi_trk_pkg::*;

    logic clk;
    logic rst_n;

    int unsigned   n_chk;
    int unsigned   n_pass;
    logic [31:0]   exp_q[$];
    logic [63:0]   exp_order;

    rvfi_retire_tracker_if #(.DEPTH(3), .LANES(2), .ORDER_W(64)) bus ();

    rvfi_retire_tracker #(
        .DEPTH     (3),
        .LANES     (2),
        .MEM_STAGE (1),
        .ORDER_W   (64)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk = n_chk + 1;
        if (obs === exp) begin
            n_pass = n_pass + 1;
        end else begin
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.in_valid = '0;
        bus.in_rec   = '0;
        bus.stall    = '0;
        bus.flush    = '0;
        bus.late_rec = '0;
    endtask

    task automatic put(input int lane, input logic [31:0] pc, input logic [4:0] rd, input bit push);
        rec_t r;
        r              = '0;
        r.inst         = 32'h0000_0013;
        r.pc_rdata     = pc;
        r.rs1_addr     = 5'd2;
        r.rd_addr      = rd;
        r.load_regfile = 1'b1;
        bus.in_rec[lane]   = r;
        bus.in_valid[lane] = 1'b1;
        if (push) exp_q.push_back(pc);
    endtask

    task automatic put2(input logic [31:0] pc, input bit push);
        put(0, pc, 5'd1, push);
        put(1, pc + 32'd4, 5'd1, push);
    endtask

    task automatic settle();
        #2;
    endtask

    // Every committing lane must be the next expected pc with the next order number.
    task automatic scan();
        logic [31:0] e;
        for (int k = 0; k < 2; k++) begin
            if (bus.commit[k]) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_commit", 64'(bus.commit[k]), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("ret_pc", 64'(bus.out_rec[k].rec.pc_rdata), 64'(e));
                    chk("ret_order", bus.order[k], exp_order);
                    exp_order = exp_order + 64'd1;
                end
            end
        end
    endtask

    task automatic advance();
        scan();
        @(posedge clk);
        #1;
    endtask

    logic [1:0] exp_bub   [10];
    logic [1:0] exp_flush [8];
    logic [1:0] exp_late  [9];
    logic [1:0] exp_halt_c[10];

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        exp_order = 64'd0;
        rst_n     = 1'b0;
        idle_inputs();
        bus.wb_rd_wdata = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
        exp_bub    = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd3, 2'd3, 2'd0};
        exp_flush  = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd3, 2'd3, 2'd0};
        exp_late   = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd1, 2'd0};
        exp_halt_c = '{2'd0, 2'd0, 2'd0, 2'd1, 2'd3, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0};

        repeat (2) @(posedge clk);
        #1;
        settle();
        chk("rst_commit", 64'(bus.commit), 64'd0);
        chk("rst_halt", 64'(bus.halt), 64'd0);
        chk("rst_order0", bus.order[0], 64'd0);
        chk("rst_order1", bus.order[1], 64'd0);
        rst_n = 1'b1;
        advance();

        // Streaming: 10 cycles of dual-lane capture, first commit 3 cycles later.
        for (int c = 0; c < 14; c++) begin
            idle_inputs();
            if (c < 10) put2(32'h1000 + 32'(8 * c), 1'b1);
            settle();
            chk("stream_commit", 64'(bus.commit), (c >= 3 && c < 13) ? 64'd3 : 64'd0);
            if (c == 13) chk("stream_base", bus.order[0], 64'd20);
            advance();
        end

        // Stage-0 stall for two cycles: record B held at the input, two bubbles reach retire.
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            case (c)
                0:       put2(32'h2000, 1'b1);
                1, 2:    begin put2(32'h2010, 1'b0); bus.stall = 3'b001; end
                3:       put2(32'h2010, 1'b1);
                4:       put2(32'h2020, 1'b1);
                5:       put2(32'h2030, 1'b1);
                default: ;
            endcase
            settle();
            chk("bubble_commit", 64'(bus.commit), 64'(exp_bub[c]));
            advance();
        end

        // Flush stage 1 while it is stalled: record E vanishes, F follows D's orders.
        for (int c = 0; c < 8; c++) begin
            idle_inputs();
            case (c)
                0:       put2(32'h2800, 1'b0);
                1:       put2(32'h2810, 1'b1);
                2:       begin put2(32'h2820, 1'b0); bus.stall = 3'b011; bus.flush = 3'b010; end
                3:       put2(32'h2820, 1'b1);
                default: ;
            endcase
            settle();
            chk("flush_commit", 64'(bus.commit), 64'(exp_flush[c]));
            if (c == 5) chk("flush_order", bus.order[0], 64'd28);
            advance();
        end

        // Late merge with retire-stage stall toggling; lane 0 only.
        for (int c = 0; c < 9; c++) begin
            idle_inputs();
            case (c)
                0: put(0, 32'h3000, 5'd1, 1'b1);
                1: begin put(0, 32'h3010, 5'd1, 1'b1); bus.late_rec[0].mem_addr = 32'hBAD0; end
                2: begin bus.stall = 3'b111; bus.late_rec[0].mem_addr = 32'h100; end
                3: bus.late_rec[0].mem_addr = 32'h100;
                4: begin bus.stall = 3'b111; bus.late_rec[0].mem_addr = 32'h104; end
                5: bus.late_rec[0].mem_addr = 32'h104;
                6: begin bus.stall = 3'b111; bus.late_rec[0].mem_addr = 32'hBAD0; end
                default: ;
            endcase
            settle();
            chk("late_commit", 64'(bus.commit), 64'(exp_late[c]));
            if (c == 5) chk("late_addr_h", 64'(bus.out_rec[0].late.mem_addr), 64'h100);
            if (c == 7) chk("late_addr_i", 64'(bus.out_rec[0].late.mem_addr), 64'h104);
            advance();
        end

        // x0 writeback is forced to zero; a real destination passes wb data through.
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            if (c == 0) begin
                put(0, 32'h4000, 5'd0, 1'b1);
                put(1, 32'h4004, 5'd5, 1'b1);
            end
            settle();
            if (c == 3) begin
                chk("x0_commit", 64'(bus.commit), 64'd3);
                chk("x0_rd_wdata", 64'(bus.out_rec[0].rd_wdata), 64'd0);
                chk("rd5_rd_wdata", 64'(bus.out_rec[1].rd_wdata), 64'hDEAD_BEEF);
            end
            advance();
        end

        // Halt: pc 0 self-loop ignored; lane 1 self-loop at 0x60 sets halt, commits continue.
        for (int c = 0; c < 10; c++) begin
            idle_inputs();
            case (c)
                0: put(0, 32'h0, 5'd1, 1'b1);
                1: begin put(0, 32'h50, 5'd1, 1'b1); put(1, 32'h60, 5'd1, 1'b1); end
                3: begin bus.late_rec[0].pc_wdata = 32'h54; bus.late_rec[1].pc_wdata = 32'h60; end
                5: put(0, 32'h70, 5'd1, 1'b1);
                7: bus.late_rec[0].pc_wdata = 32'h74;
                default: ;
            endcase
            settle();
            chk("halt_commit", 64'(bus.commit), 64'(exp_halt_c[c]));
            chk("halt", 64'(bus.halt), (c >= 5) ? 64'd1 : 64'd0);
            advance();
        end

        // Reset mid-stream: in-flight records are discarded and counters restart.
        for (int c = 0; c < 13; c++) begin
            idle_inputs();
            if (c < 3) put2(32'h5000 + 32'(16 * c), 1'b0);
            if (c == 4) rst_n = 1'b1;
            if (c == 9) put(0, 32'h6000, 5'd1, 1'b1);
            settle();
            if (c == 3) begin
                chk("pre_rst_commit", 64'(bus.commit), 64'd3);
                chk("pre_rst_halt", 64'(bus.halt), 64'd1);
                rst_n = 1'b0;
                #1;
                chk("mid_rst_commit", 64'(bus.commit), 64'd0);
                chk("mid_rst_halt", 64'(bus.halt), 64'd0);
                chk("mid_rst_base", bus.order[0], 64'd0);
                exp_order = 64'd0;
            end else if (c >= 4 && c < 12) begin
                chk("post_rst_commit", 64'(bus.commit), 64'd0);
            end else if (c == 12) begin
                chk("post_rst_first", 64'(bus.commit), 64'd1);
            end
            advance();
        end

        chk("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
